imem_prog_loader: RTL

//  Consumes the 32-bit words and 1-cycle strobe produced by the UART programmer.

---
 rtl/imem_prog_loader.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/imem_prog_loader.sv
// Instruction-memory reload sequencer: takes header + payload words from the UART
// programmer, writes them into imem and holds the CPU in reset around the reload.
module imem_prog_loader #(
   parameter int          AW        = 12,
   parameter int          BASE_ADDR = 0,
   parameter logic [15:0] MAGIC     = 16'hB007,
   parameter int          TIMEOUT   = 2_000_000,
   parameter int          HOLD_CYC  = 16
) (
   input  logic          clk,
   input  logic          Rst,
   input  logic [31:0]   prog_word,
   input  logic          prog_valid,
   input  logic [AW-1:0] cpu_addr,
   output logic [AW-1:0] imem_addr,
   output logic [31:0]   imem_din,
   output logic          imem_we,
   output logic          state_load_prog,
   output logic          cpu_rst,
   output logic          load_done,
   output logic          load_err
);

   localparam int          TW  = $clog2(TIMEOUT + 1);
   localparam int          HW  = $clog2(HOLD_CYC + 1);
   localparam logic [32:0] CAP = (33'd1 << AW) - 33'(BASE_ADDR);

   typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

   state_t        state;
   state_t        state_next;
   logic [AW-1:0] wr_addr;
   logic [15:0]   remaining;
   logic [TW-1:0] timer;
   logic [HW-1:0] hold_cnt;

   logic [15:0] hdr_len;
   logic        hdr_magic_ok;
   logic        hdr_len_ok;
   logic        accept;
   logic        last_write;
   logic        timer_expire;

   assign hdr_len      = prog_word[15:0];
   assign hdr_magic_ok = (prog_word[31:16] == MAGIC);
   assign hdr_len_ok   = ({17'd0, hdr_len} <= CAP);

   // remaining counts words still to be accepted, so it reads 0 during the last write
   assign accept       = (state == LOAD) && prog_valid && (remaining != 16'd0);
   assign last_write   = (state == LOAD) && imem_we && (remaining == 16'd0);
   assign timer_expire = (state == LOAD) && !prog_valid && (timer <= TW'(1));

   assign imem_addr       = (state == LOAD) ? wr_addr : cpu_addr;
   assign state_load_prog = (state == LOAD);

   always_ff @(posedge clk) begin
      if (Rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (prog_valid && hdr_magic_ok) begin
               if (hdr_len == 16'd0)  state_next = HOLD;
               else if (hdr_len_ok)   state_next = LOAD;
            end
         end
         LOAD: begin
            if (last_write)        state_next = HOLD;
            else if (timer_expire) state_next = IDLE;
         end
         HOLD: begin
            if (hold_cnt == '0) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // hold_cnt is loaded so cpu_rst stays high exactly HOLD_CYC cycles after the load_done cycle
   always_ff @(posedge clk) begin
      if (Rst) begin
         wr_addr   <= AW'(BASE_ADDR);
         remaining <= '0;
         timer     <= '0;
         hold_cnt  <= '0;
         imem_we   <= 1'b0;
         imem_din  <= '0;
         cpu_rst   <= 1'b0;
         load_done <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         imem_we   <= 1'b0;
         load_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (prog_valid) begin
                  if (hdr_magic_ok && hdr_len == 16'd0) begin
                     load_done <= 1'b1;
                     cpu_rst   <= 1'b1;
                     hold_cnt  <= HW'(HOLD_CYC);
                  end else if (hdr_magic_ok && hdr_len_ok) begin
                     remaining <= hdr_len;
                     wr_addr   <= AW'(BASE_ADDR);
                     timer     <= TW'(TIMEOUT);
                     load_err  <= 1'b0;
                     cpu_rst   <= 1'b1;
                  end else begin
                     load_err  <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (accept) begin
                  imem_we   <= 1'b1;
                  imem_din  <= prog_word;
                  remaining <= remaining - 16'd1;
                  if (remaining == 16'd1) load_done <= 1'b1;
               end
               if (imem_we) wr_addr <= wr_addr + AW'(1);
               if (prog_valid)           timer <= TW'(TIMEOUT);
               else if (timer != '0)     timer <= timer - TW'(1);
               if (last_write) begin
                  hold_cnt <= HW'(HOLD_CYC - 1);
               end else if (timer_expire) begin
                  load_err <= 1'b1;
                  cpu_rst  <= 1'b0;
               end
            end
            HOLD: begin
               if (hold_cnt == '0) cpu_rst  <= 1'b0;
               else                hold_cnt <= hold_cnt - HW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule
